// File: rtl/uart_bus_responder.sv
// rtl/uart_bus_responder.sv - memory-mapped 8N1 UART with TX FIFO, RX holding register and sticky error flags
module uart_bus_responder #(
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_DEFAULT = 234,
    parameter int DIV_MIN     = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  addr,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    input  logic        rx
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0]     DIV_RST  = 16'(DIV_DEFAULT);
    localparam logic [15:0]     DIV_LO   = 16'(DIV_MIN);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

    logic              sel_data, sel_stat, sel_div;
    logic              wr_data, rd_data, wr_stat, wr_div;
    logic              unused_bits;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic              fifo_full, fifo_empty, push_ok, push_drop, tx_pop;

    logic [15:0]       div_q;

    uart_state_e       tx_state_q;
    logic [15:0]       tx_cnt_q;
    logic [2:0]        tx_bit_q;
    logic [7:0]        tx_sh_q;
    logic              tx_q;

    uart_state_e       rx_state_q;
    logic              rx_s1_q, rx_s2_q, rx_s3_q;
    logic [15:0]       rx_cnt_q;
    logic [2:0]        rx_bit_q;
    logic [7:0]        rx_sh_q;
    logic              rx_wait_q;
    logic              rx_stop_tick, rx_good, rx_bad;

    logic              rx_valid_q, rx_overrun_q, frame_err_q, tx_drop_q;
    logic [7:0]        rx_data_q;
    logic [6:0]        status;

    assign unused_bits = ^{addr[1:0], wdata[31:16]};

    assign sel_data = (addr[3:2] == 2'd0);
    assign sel_stat = (addr[3:2] == 2'd1);
    assign sel_div  = (addr[3:2] == 2'd2);
    assign wr_data  = wen & sel_data;
    assign rd_data  = ren & sel_data;
    assign wr_stat  = wen & sel_stat;
    assign wr_div   = wen & sel_div;

    // Fullness is judged on the registered count, so a same-cycle pop never rescues a push.
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign push_ok    = wr_data & ~fifo_full;
    assign push_drop  = wr_data & fifo_full;
    assign tx_pop     = ~fifo_empty &
                        ((tx_state_q == S_IDLE) || (tx_state_q == S_STOP && tx_cnt_q == 16'd0));

    always_comb begin
        count_d = count_q;
        case ({push_ok, tx_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= wdata[7:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            div_q    <= DIV_RST;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (tx_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (wr_div) div_q <= (wdata[15:0] < DIV_LO) ? DIV_LO : wdata[15:0];
        end
    end

    // Every bit boundary reloads from div_q, so a divisor change lands on the next bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (tx_state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (tx_pop) begin
                        tx_sh_q    <= fifo_mem[rd_ptr_q];
                        tx_cnt_q   <= div_q - 16'd1;
                        tx_q       <= 1'b0;
                        tx_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt_q == 16'd0) begin
                        tx_q       <= tx_sh_q[0];
                        tx_sh_q    <= {1'b0, tx_sh_q[7:1]};
                        tx_bit_q   <= '0;
                        tx_cnt_q   <= div_q - 16'd1;
                        tx_state_q <= S_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt_q == 16'd0) begin
                        tx_cnt_q <= div_q - 16'd1;
                        tx_bit_q <= tx_bit_q + 3'd1;
                        if (tx_bit_q == 3'd7) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= S_STOP;
                        end else begin
                            tx_q    <= tx_sh_q[0];
                            tx_sh_q <= {1'b0, tx_sh_q[7:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                default: begin
                    if (tx_cnt_q == 16'd0) begin
                        if (tx_pop) begin
                            tx_sh_q    <= fifo_mem[rd_ptr_q];
                            tx_cnt_q   <= div_q - 16'd1;
                            tx_q       <= 1'b0;
                            tx_state_q <= S_START;
                        end else begin
                            tx_q       <= 1'b1;
                            tx_state_q <= S_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
            endcase
        end
    end

    assign rx_stop_tick = (rx_state_q == S_STOP) && !rx_wait_q && (rx_cnt_q == 16'd0);
    assign rx_good      = rx_stop_tick & rx_s2_q;
    assign rx_bad       = rx_stop_tick & ~rx_s2_q;

    // rx_s3_q is the previous synchronized level, used only for falling-edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_wait_q  <= 1'b0;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
            case (rx_state_q)
                S_IDLE: begin
                    if (rx_s3_q && !rx_s2_q) begin
                        rx_cnt_q   <= (div_q >> 1) - 16'd1;
                        rx_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt_q == 16'd0) begin
                        rx_cnt_q   <= div_q - 16'd1;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt_q == 16'd0) begin
                        rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                        rx_cnt_q <= div_q - 16'd1;
                        rx_bit_q <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                default: begin
                    if (rx_wait_q) begin
                        if (rx_s2_q) begin
                            rx_wait_q  <= 1'b0;
                            rx_state_q <= S_IDLE;
                        end
                    end else if (rx_cnt_q == 16'd0) begin
                        if (rx_s2_q) rx_state_q <= S_IDLE;
                        else         rx_wait_q  <= 1'b1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
            endcase
        end
    end

    // Sets take priority over both the DATA-read clear and the W1C clears.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_valid_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
            tx_drop_q    <= 1'b0;
        end else begin
            if (rx_good) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= rx_sh_q;
            end else if (rd_data) begin
                rx_valid_q <= 1'b0;
            end
            rx_overrun_q <= (rx_overrun_q & ~(wr_stat & wdata[4])) | (rx_good & rx_valid_q & ~rd_data);
            frame_err_q  <= (frame_err_q  & ~(wr_stat & wdata[5])) | rx_bad;
            tx_drop_q    <= (tx_drop_q    & ~(wr_stat & wdata[6])) | push_drop;
        end
    end

    assign status = {tx_drop_q, frame_err_q, rx_overrun_q, rx_valid_q,
                     (tx_state_q != S_IDLE), fifo_empty, fifo_full};

    always_comb begin
        rdata = 32'd0;
        case (addr[3:2])
            2'd0:    rdata = {23'd0, rx_valid_q, rx_data_q};
            2'd1:    rdata = {25'd0, status};
            2'd2:    rdata = {16'd0, div_q};
            default: rdata = 32'd0;
        endcase
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_uart_bus_responder.sv
// tb/tb_uart_bus_responder.sv - randomized self-checking bench for uart_bus_responder
module tb_uart_bus_responder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  addr = '0;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        tx;
    logic        rx = 1'b1;

    int checks = 0;
    int errors = 0;
    int tb_div = 16;

    logic [8:0]  tx_got [$];
    logic [7:0]  tx_exp [$];

    logic        m_valid, m_ovr, m_ferr;
    logic [7:0]  m_data;

    logic [7:0]  mon_b;
    logic        mon_s;
    int          mon_d;

    uart_bus_responder dut (
        .clk    (clk),
        .resetn (resetn),
        .addr   (addr),
        .ren    (ren),
        .wen    (wen),
        .wdata  (wdata),
        .rdata  (rdata),
        .tx     (tx),
        .rx     (rx)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wen = 1'b1;
        @(posedge clk);
        #1 wen = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; ren = 1'b1;
        #1 d = rdata;
        @(posedge clk);
        #1 ren = 1'b0;
    endtask

    task automatic set_div(input int d);
        bus_write(4'h8, 32'(d));
        tb_div = d;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit, input int d);
        @(negedge clk);
        rx = 1'b0;
        repeat (d) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (d) @(negedge clk);
        end
        rx = stop_bit;
        repeat (d) @(negedge clk);
        rx = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_tx_idle(input string tag);
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            addr = 4'h4;
            #1;
            if (rdata[2:0] == 3'b010) break;
        end
        check_eq(tag, {29'd0, rdata[2:0]}, 32'h2);
        repeat (2) @(negedge clk);
    endtask

    task automatic compare_tx(input string tag);
        check_eq({tag, "_count"}, tx_got.size(), tx_exp.size());
        for (int i = 0; i < tx_exp.size() && i < tx_got.size(); i++)
            check_eq($sformatf("%s_byte%0d", tag, i), {23'd0, tx_got[i]}, {23'd0, 1'b1, tx_exp[i]});
    endtask

    function automatic logic [31:0] model_status(input logic drop);
        return {25'd0, drop, m_ferr, m_ovr, m_valid, 1'b0, 1'b1, 1'b0};
    endfunction

    // Line monitor: decode any 8N1 frame at the current divisor, sampling at bit centres.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && tx === 1'b0) begin
                mon_d = tb_div;
                repeat (mon_d / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_d) @(negedge clk);
                    mon_b[i] = tx;
                end
                repeat (mon_d) @(negedge clk);
                mon_s = tx;
                tx_got.push_back({mon_s, mon_b});
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [9:0]  fr;
        logic [7:0]  b;
        logic        sb, exp_tx, exp_busy;
        int          k, dv, bad_tx, bad_busy, lows;
        logic [31:0] mask;

        repeat (3) @(negedge clk);
        check_eq("tx_in_reset", {31'd0, tx}, 32'd1);
        resetn = 1'b1;

        bus_read(4'h4, d); check_eq("rst_status", d, 32'h02);
        bus_read(4'h8, d); check_eq("rst_div", d, 32'd234);
        bus_read(4'h0, d); check_eq("rst_data", d, 32'h0);
        bus_read(4'hC, d); check_eq("rst_reserved", d, 32'h0);
        check_eq("rst_tx", {31'd0, tx}, 32'd1);

        bus_write(4'h8, 32'd5);        bus_read(4'h8, d); check_eq("div_clamp", d, 32'd16);
        bus_write(4'hB, 32'h0001_0030); bus_read(4'h8, d); check_eq("div_16bit", d, 32'h30);
        bus_write(4'hC, 32'hFFFF_FFFF); bus_read(4'hC, d); check_eq("reserved_wr", d, 32'h0);
        bus_read(4'h4, d); check_eq("status_after_misc", d, 32'h02);

        // Cycle-exact frame for 0xA5 at DIV=16: n counts negedges after the push edge.
        set_div(16);
        tx_got.delete();
        bus_write(4'h0, 32'hA5);
        fr = {1'b1, 8'hA5, 1'b0};
        bad_tx = 0; bad_busy = 0;
        for (int n = 0; n <= 161; n++) begin
            @(negedge clk);
            addr = 4'h4;
            #1;
            exp_busy = (n >= 1 && n <= 160);
            exp_tx   = exp_busy ? fr[(n - 1) / 16] : 1'b1;
            if (tx !== exp_tx) bad_tx++;
            if (rdata[2] !== exp_busy) bad_busy++;
        end
        check_eq("a5_tx_bad_cycles", bad_tx, 0);
        check_eq("a5_busy_bad_cycles", bad_busy, 0);
        bus_read(4'h4, d); check_eq("a5_status_after", d, 32'h02);
        tx_exp.delete(); tx_exp.push_back(8'hA5);
        compare_tx("a5_mon");

        // Ten back-to-back pushes: one enters the FSM, eight fill the FIFO, the tenth drops.
        tx_got.delete(); tx_exp.delete();
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            bus_write(4'h0, {24'd0, b});
            if (i < 9) tx_exp.push_back(b);
        end
        bus_read(4'h4, d); check_eq("burst_full_drop", d, 32'h45);
        bus_write(4'h4, 32'h40);
        bus_read(4'h4, d); check_eq("burst_drop_w1c", d, 32'h05);
        wait_tx_idle("burst_drain");
        compare_tx("burst");

        for (int r = 0; r < 3; r++) begin
            dv = $urandom_range(16, 24);
            set_div(dv);
            k = $urandom_range(1, 10);
            tx_got.delete(); tx_exp.delete();
            for (int i = 0; i < k; i++) begin
                b = 8'($urandom);
                bus_write(4'h0, {24'd0, b});
                if (i < 9) tx_exp.push_back(b);
            end
            bus_read(4'h4, d);
            check_eq($sformatf("rnd_tx%0d_drop", r), {31'd0, d[6]}, {31'd0, (k > 9)});
            bus_write(4'h4, 32'h40);
            wait_tx_idle($sformatf("rnd_tx%0d_drain", r));
            compare_tx($sformatf("rnd_tx%0d", r));
        end

        set_div(16);
        rx_frame(8'h3C, 1'b1, 16);
        bus_read(4'h0, d); check_eq("rx_3c", d, 32'h13C);
        bus_read(4'h0, d); check_eq("rx_3c_cleared", d, 32'h03C);
        rx_frame(8'h5A, 1'b1, 16);
        rx_frame(8'h77, 1'b1, 16);
        bus_read(4'h4, d); check_eq("rx_overrun_status", d, 32'h1A);
        bus_read(4'h0, d); check_eq("rx_overwrite", d, 32'h177);
        bus_write(4'h4, 32'h10);
        bus_read(4'h4, d); check_eq("rx_overrun_w1c", d, 32'h02);
        rx_frame(8'h55, 1'b0, 16);
        bus_read(4'h4, d); check_eq("rx_frame_err", d, 32'h22);
        bus_write(4'h4, 32'h20);
        @(negedge clk); rx = 1'b0;
        repeat (4) @(negedge clk); rx = 1'b1;
        repeat (40) @(negedge clk);
        bus_read(4'h4, d); check_eq("rx_glitch_status", d, 32'h02);
        bus_read(4'h0, d); check_eq("rx_glitch_data", d, 32'h077);

        m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_data = 8'h77;
        for (int r = 0; r < 10; r++) begin
            dv = $urandom_range(16, 31);
            set_div(dv);
            b  = 8'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            rx_frame(b, sb, dv);
            if (sb) begin
                if (m_valid) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_data  = b;
            end else begin
                m_ferr = 1'b1;
            end
            bus_read(4'h4, d); check_eq($sformatf("rnd_rx%0d_status", r), d, model_status(1'b0));
            if ($urandom_range(0, 1) == 1) begin
                bus_read(4'h0, d);
                check_eq($sformatf("rnd_rx%0d_data", r), d, {23'd0, m_valid, m_data});
                m_valid = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) begin
                mask = 32'($urandom_range(0, 3)) << 4;
                bus_write(4'h4, mask);
                if (mask[4]) m_ovr  = 1'b0;
                if (mask[5]) m_ferr = 1'b0;
            end
        end

        // Reset in the middle of a frame with three bytes still queued.
        set_div(16);
        for (int i = 0; i < 4; i++) bus_write(4'h0, 32'($urandom_range(0, 255)));
        repeat (40) @(negedge clk);
        resetn = 1'b0;
        addr = 4'h4;
        #1;
        check_eq("mid_reset_tx", {31'd0, tx}, 32'd1);
        check_eq("mid_reset_status", rdata, 32'h02);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        tb_div = 234;
        bus_read(4'h4, d); check_eq("post_reset_status", d, 32'h02);
        bus_read(4'h8, d); check_eq("post_reset_div", d, 32'd234);
        lows = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check_eq("post_reset_tx_idle", lows, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
